if_fetch_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and issues requests to a multi-cycle instruction memory using a req/ready handshake.
- Presents the fetched instruction to the decode stage and to the hazard detection unit.
- Consumes the hazard unit's stall and the decode stage's branch flush/redirect.

---
 rtl/if_fetch_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner, instruction-memory requester and IF/ID pipeline
// register for the 5-stage MIPS pipeline. Talks to a multi-cycle instruction
// memory over req/ready, honours load-use stalls and branch flush/redirects.
// Optional macro FETCH_PERF_CNT_EN adds stall-cycle and flush counters; when
// it is undefined both counter ports are tied to zero.
module if_fetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  if_id_pc_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic               if_id_valid_o,
    output logic [31:0]        stall_cycles_o,
    output logic [31:0]        flush_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    if_id_pc_q, if_id_pc_d;
    logic [INSTR_W-1:0]   if_id_instr_q, if_id_instr_d;
    logic                 if_id_valid_q, if_id_valid_d;
    logic [ADDR_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]    redirect_q, redirect_d;

    // Candidate instruction for IF/ID this cycle (fresh from memory or from the skid buffer)
    logic                 ld_valid;
    logic [ADDR_W-1:0]    ld_pc;
    logic [INSTR_W-1:0]   ld_instr;
    logic                 req;
    logic [ADDR_W-1:0]    pc_plus4;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // State, PC and pipeline register update
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= '0;
            redirect_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            redirect_q    <= redirect_d;
        end
    end

    // Next-state, PC selection, skid/redirect capture and IF/ID load decision
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        redirect_d   = redirect_q;
        req          = 1'b0;
        ld_valid     = 1'b0;
        ld_pc        = '0;
        ld_instr     = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                req = 1'b1;
                if (imem_ready_i) begin
                    if (flush_i) begin
                        // Returned word is on the wrong path; go straight to the target
                        pc_d = branch_target_i;
                    end else if (stall_i) begin
                        // Data arrived during a stall: park it until decode can accept it
                        skid_instr_d = imem_instr_i;
                        skid_pc_d    = pc_plus4;
                        state_d      = S_HOLD;
                    end else begin
                        ld_valid = 1'b1;
                        ld_pc    = pc_plus4;
                        ld_instr = imem_instr_i;
                        pc_d     = pc_plus4;
                    end
                end else if (flush_i) begin
                    // Request in flight: keep its address stable, redirect once it completes
                    redirect_d = branch_target_i;
                    state_d    = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    pc_d         = branch_target_i;
                    state_d      = S_FETCH;
                end else if (!stall_i) begin
                    ld_valid     = 1'b1;
                    ld_pc        = skid_pc_q;
                    ld_instr     = skid_instr_q;
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    pc_d         = pc_plus4;
                    state_d      = S_FETCH;
                end
            end
            S_DRAIN: begin
                req = 1'b1;
                if (flush_i) redirect_d = branch_target_i;
                if (imem_ready_i) begin
                    // The newest redirect wins, including one arriving this very cycle
                    pc_d    = flush_i ? branch_target_i : redirect_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (state_q != S_IDLE) begin
            if (flush_i) begin
                if_id_pc_d    = '0;
                if_id_instr_d = '0;
                if_id_valid_d = 1'b0;
            end else if (!stall_i) begin
                // Load the candidate, or a bubble (ld_* default to zero)
                if_id_pc_d    = ld_pc;
                if_id_instr_d = ld_instr;
                if_id_valid_d = ld_valid;
            end
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Performance counters: stalled cycles and flushes while active
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else if (state_q != S_IDLE) begin
            if (flush_i)      flush_count_q  <= flush_count_q + 32'd1;
            else if (stall_i) stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule
